if_fetch_unit: RTL

//  Instruction-fetch stage sitting directly upstream of ID_top. Owns the fetch PC, issues

---
 rtl/if_fetch_unit_if.sv | 37 +++
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, EX redirect and the ID-facing instruction handshake.
// Latency: none, wiring only.
// Backpressure: imem_ready stalls requests and id_ready stalls delivery toward decode.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        id_ready;
    logic        halted;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        input  redirect, redirect_target,
        output instr_valid, instr, instr_pc,
        input  id_ready,
        output halted
    );

    // Memory / EX / ID side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        output redirect, redirect_target,
        input  instr_valid, instr, instr_pc,
        output id_ready,
        input  halted
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns fetch PC, one outstanding imem request, FIFO_DEPTH-entry buffer of {pc, word} toward ID.
// Latency: accept in cycle N, rvalid in N+k -> instr_valid in N+k+1; best case one instruction per 2 cycles.
// Backpressure: id_ready low fills the buffer; imem_req is withheld while no slot is free. Optional HALT_DETECT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DISCARD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [31:0]       instr_mem_q [FIFO_DEPTH];
    logic [31:0]       instr_mem_d [FIFO_DEPTH];
    logic [31:0]       pc_mem_q [FIFO_DEPTH];
    logic [31:0]       pc_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic accept;
    logic push;
    logic pop;
    logic halt_active;
    logic halt_next;

    assign accept = imem_req_q && bus.imem_ready;
    assign pop    = (count_q != '0) && bus.id_ready;
    // A response is kept only in WAIT, when no redirect kills it and fetch is not halted.
    assign push   = (state_q == ST_WAIT) && bus.imem_rvalid && !bus.redirect && !halt_active;

    // Next fetch state and PC; a redirect always wins the PC and turns a live request into a discard.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            ST_REQ: begin
                if (accept) state_d = bus.redirect ? ST_DISCARD : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = ST_REQ;
                    if (push) fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (bus.redirect) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (bus.imem_rvalid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
        if (bus.redirect) fetch_pc_d = bus.redirect_target & 32'hFFFF_FFFC;
        // Request only from REQ with room for the reply, so a push can never overflow.
        imem_req_d = (state_d == ST_REQ) && (count_d < DEPTH_C) && !halt_next;
    end

    // Fetch buffer bookkeeping; a redirect empties it and overrides any same-cycle push/pop.
    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    // FSM, fetch PC, registered request and buffer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_REQ;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            instr_mem_q <= '{default: '0};
            pc_mem_q    <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

`ifdef HALT_DETECT_EN
    localparam logic [31:0] HALT_INSTR = 32'h0000_006F;
    logic halted_q, halted_d;

    // Halt once decode consumes the self-jump; redirects do not release it, only reset does.
    always_comb begin
        halted_d = halted_q;
        if (pop && (instr_mem_q[rd_ptr_q] == HALT_INSTR)) halted_d = 1'b1;
    end

    // Sticky halt flag.
    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end

    assign halt_active = halted_q;
    assign halt_next   = halted_d;
`else
    assign halt_active = 1'b0;
    assign halt_next   = 1'b0;
`endif

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = instr_mem_q[rd_ptr_q];
    assign bus.instr_pc    = pc_mem_q[rd_ptr_q];
    assign bus.halted      = halt_active;
endmodule
